// File: rtl/core_sequencer_pkg.sv
// Shared state encodings, trap causes and rv32i opcode decode helpers for core_sequencer.
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_FETCH  = 3'd0,
        SEQ_DECODE = 3'd1,
        SEQ_EXEC   = 3'd2,
        SEQ_MEM    = 3'd3,
        SEQ_WB     = 3'd4,
        SEQ_TRAP   = 3'd5
    } seq_state_e;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'd0,
        TRAP_ILLEGAL = 2'd1,
        TRAP_SYSTEM  = 2'd2,
        TRAP_TIMEOUT = 2'd3
    } trap_cause_e;

    localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR  = 7'b1100111;
    localparam logic [6:0] OPCODE_B     = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_S     = 7'b0100011;
    localparam logic [6:0] OPCODE_I     = 7'b0010011;
    localparam logic [6:0] OPCODE_R     = 7'b0110011;
    localparam logic [6:0] OPCODE_FENCE = 7'b0001111;
    localparam logic [6:0] OPCODE_I_CSR = 7'b1110011;

    function automatic logic opcode_legal(input logic [6:0] op);
        logic ok;
        case (op)
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_B,
            OPCODE_LOAD, OPCODE_S, OPCODE_I, OPCODE_R, OPCODE_FENCE: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic opcode_writes_rd(input logic [6:0] op);
        logic wr;
        case (op)
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR,
            OPCODE_LOAD, OPCODE_I, OPCODE_R: wr = 1'b1;
            default: wr = 1'b0;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/core_sequencer_mem_watchdog.sv
// seq_mem_watchdog: counts memory wait cycles and flags expiry at MEM_TIMEOUT.
module seq_mem_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic wait_i,
    output logic expire_o
);

    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // next count: clear on state entry, otherwise advance on each wait cycle
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (wait_i) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // expire on the wait cycle that would bring the count up to MEM_TIMEOUT
    assign expire_o = wait_i && (count_q == LAST_WAIT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle rv32i sequencer: FETCH/DECODE/EXEC/MEM/WB timing, shared memory handshake, traps.
// Optional memory-wait watchdog enabled by defining SEQ_MEM_TIMEOUT_EN.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        regfile_we,
    output logic [2:0]  state,
    output logic        halted,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be in 1..255");
    end

    seq_state_e  state_q, state_d;
    trap_cause_e cause_q, cause_d;
    logic [31:0] instret_q, instret_d;
    logic        wd_expire_s;
    logic        mem_req_s, mem_we_s, addr_sel_s, ir_we_s, pc_we_s, rf_we_s;

`ifdef SEQ_MEM_TIMEOUT_EN
    logic mem_wait_s;
    assign mem_wait_s = mem_req && !mem_ready;

    seq_mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_d != state_q),
        .wait_i   (mem_wait_s),
        .expire_o (wd_expire_s)
    );
`else
    assign wd_expire_s = 1'b0;
`endif

    // next-state, trap latch, retire count and strobes
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        instret_d  = instret_q;
        mem_req_s  = 1'b0;
        mem_we_s   = 1'b0;
        addr_sel_s = 1'b0;
        ir_we_s    = 1'b0;
        pc_we_s    = 1'b0;
        rf_we_s    = 1'b0;
        case (state_q)
            SEQ_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_we_s = 1'b1;
                    state_d = SEQ_DECODE;
                end else if (wd_expire_s) begin
                    state_d = SEQ_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end else begin
                    state_d = SEQ_FETCH;
                end
            end
            SEQ_DECODE: begin
                if (opcode == OPCODE_I_CSR) begin
                    state_d = SEQ_TRAP;
                    cause_d = TRAP_SYSTEM;
                end else if (!opcode_legal(opcode)) begin
                    state_d = SEQ_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end else begin
                    state_d = SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                if (opcode == OPCODE_LOAD || opcode == OPCODE_S) begin
                    state_d = SEQ_MEM;
                end else begin
                    state_d = SEQ_WB;
                end
            end
            SEQ_MEM: begin
                mem_req_s  = 1'b1;
                addr_sel_s = 1'b1;
                mem_we_s   = (opcode == OPCODE_S);
                if (mem_ready) begin
                    // a store has nothing to write back, so it retires here
                    if (opcode == OPCODE_S) begin
                        pc_we_s   = 1'b1;
                        instret_d = instret_q + 32'd1;
                        state_d   = SEQ_FETCH;
                    end else begin
                        state_d = SEQ_WB;
                    end
                end else if (wd_expire_s) begin
                    state_d = SEQ_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end else begin
                    state_d = SEQ_MEM;
                end
            end
            SEQ_WB: begin
                pc_we_s   = 1'b1;
                rf_we_s   = opcode_writes_rd(opcode);
                instret_d = instret_q + 32'd1;
                state_d   = SEQ_FETCH;
            end
            SEQ_TRAP: begin
                state_d = SEQ_TRAP;
            end
            default: begin
                state_d = SEQ_TRAP;
                cause_d = TRAP_ILLEGAL;
            end
        endcase
    end

    // state, trap cause and retire counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEQ_FETCH;
            cause_q   <= TRAP_NONE;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    // rst overrides everything combinationally so a withdrawn request drops in the reset cycle
    assign mem_req      = mem_req_s  && !rst;
    assign mem_we       = mem_we_s   && !rst;
    assign mem_addr_sel = addr_sel_s && !rst;
    assign ir_we        = ir_we_s    && !rst;
    assign pc_we        = pc_we_s    && !rst;
    assign regfile_we   = rf_we_s    && !rst;
    assign state        = rst ? SEQ_FETCH : state_q;
    assign halted       = (state_q == SEQ_TRAP) && !rst;
    assign trap_cause   = rst ? TRAP_NONE : cause_q;
    assign instret      = rst ? 32'd0 : instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer; watchdog checks compile with SEQ_MEM_TIMEOUT_EN.
module tb_core_sequencer;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, regfile_we;
    logic [2:0]  state;
    logic        halted;
    logic [1:0]  trap_cause;
    logic [31:0] instret;

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b0000000;
    localparam logic [6:0] OP_CSR = 7'b1110011;

    // strobe vector order: {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, regfile_we}
    localparam logic [5:0] S_NONE  = 6'b000000;
    localparam logic [5:0] S_FWAIT = 6'b100000;
    localparam logic [5:0] S_FETCH = 6'b100100;
    localparam logic [5:0] S_LD    = 6'b101000;
    localparam logic [5:0] S_STW   = 6'b111000;
    localparam logic [5:0] S_STD   = 6'b111010;
    localparam logic [5:0] S_WBR   = 6'b000011;
    localparam logic [5:0] S_WBB   = 6'b000010;

    core_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .regfile_we   (regfile_we),
        .state        (state),
        .halted       (halted),
        .trap_cause   (trap_cause),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // inputs change 1 time unit after the edge, outputs are sampled 1 unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic rdy, input logic [2:0] exp_state,
                       input logic [5:0] exp_strobe);
        mem_ready = rdy;
        #1;
        check_eq({tag, ".state"}, 32'(state), 32'(exp_state));
        check_eq({tag, ".strobe"},
                 32'({mem_req, mem_we, mem_addr_sel, ir_we, pc_we, regfile_we}),
                 32'(exp_strobe));
        tick();
    endtask

    task automatic check_status(input string tag, input logic h, input logic [1:0] c,
                                input logic [31:0] n);
        #1;
        check_eq({tag, ".halted"}, 32'(halted), 32'(h));
        check_eq({tag, ".cause"}, 32'(trap_cause), 32'(c));
        check_eq({tag, ".instret"}, instret, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_eq("rst.strobe",
                 32'({mem_req, mem_we, mem_addr_sel, ir_we, pc_we, regfile_we}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        opcode = OP_ADD;
        mem_ready = 1'b1;
        tick();
        do_reset();
        check_status("reset", 1'b0, 2'd0, 32'd0);
        check_eq("reset.state", 32'(state), 32'd0);

        // ADD, zero-wait: 4 cycles
        opcode = OP_ADD;
        cyc("add.c1", 1'b1, 3'd0, S_FETCH);
        cyc("add.c2", 1'b1, 3'd1, S_NONE);
        cyc("add.c3", 1'b1, 3'd2, S_NONE);
        cyc("add.c4", 1'b1, 3'd4, S_WBR);
        check_status("add.done", 1'b0, 2'd0, 32'd1);

        // LW with three wait cycles in MEM: 8 cycles
        opcode = OP_LW;
        cyc("lw.c1", 1'b1, 3'd0, S_FETCH);
        cyc("lw.c2", 1'b1, 3'd1, S_NONE);
        cyc("lw.c3", 1'b1, 3'd2, S_NONE);
        cyc("lw.c4", 1'b0, 3'd3, S_LD);
        cyc("lw.c5", 1'b0, 3'd3, S_LD);
        cyc("lw.c6", 1'b0, 3'd3, S_LD);
        cyc("lw.c7", 1'b1, 3'd3, S_LD);
        cyc("lw.c8", 1'b1, 3'd4, S_WBR);
        check_status("lw.done", 1'b0, 2'd0, 32'd2);

        // SW: retires from MEM straight back to FETCH
        opcode = OP_SW;
        cyc("sw.c1", 1'b1, 3'd0, S_FETCH);
        cyc("sw.c2", 1'b1, 3'd1, S_NONE);
        cyc("sw.c3", 1'b1, 3'd2, S_NONE);
        cyc("sw.c4", 1'b1, 3'd3, S_STD);
        check_status("sw.done", 1'b0, 2'd0, 32'd3);

        // BEQ with one fetch wait: no register write
        opcode = OP_BEQ;
        cyc("beq.c1", 1'b0, 3'd0, S_FWAIT);
        cyc("beq.c2", 1'b1, 3'd0, S_FETCH);
        cyc("beq.c3", 1'b1, 3'd1, S_NONE);
        cyc("beq.c4", 1'b1, 3'd2, S_NONE);
        cyc("beq.c5", 1'b1, 3'd4, S_WBB);
        check_status("beq.done", 1'b0, 2'd0, 32'd4);

        // illegal opcode traps after DECODE; mem_ready ignored in TRAP
        opcode = OP_BAD;
        cyc("ill.c1", 1'b1, 3'd0, S_FETCH);
        cyc("ill.c2", 1'b1, 3'd1, S_NONE);
        cyc("ill.c3", 1'b1, 3'd5, S_NONE);
        cyc("ill.c4", 1'b1, 3'd5, S_NONE);
        check_status("ill.trap", 1'b1, 2'd1, 32'd4);
        do_reset();
        check_status("ill.rst", 1'b0, 2'd0, 32'd0);

        // CSR/system opcode
        opcode = OP_CSR;
        cyc("csr.c1", 1'b1, 3'd0, S_FETCH);
        cyc("csr.c2", 1'b1, 3'd1, S_NONE);
        cyc("csr.c3", 1'b0, 3'd5, S_NONE);
        check_status("csr.trap", 1'b1, 2'd2, 32'd0);
        do_reset();

        // complete one ADD, then reset during a store's MEM wait with mem_ready arriving
        opcode = OP_ADD;
        cyc("pre.c1", 1'b1, 3'd0, S_FETCH);
        cyc("pre.c2", 1'b1, 3'd1, S_NONE);
        cyc("pre.c3", 1'b1, 3'd2, S_NONE);
        cyc("pre.c4", 1'b1, 3'd4, S_WBR);
        opcode = OP_SW;
        cyc("srst.c1", 1'b1, 3'd0, S_FETCH);
        cyc("srst.c2", 1'b1, 3'd1, S_NONE);
        cyc("srst.c3", 1'b1, 3'd2, S_NONE);
        cyc("srst.c4", 1'b0, 3'd3, S_STW);
        rst = 1'b1;
        cyc("srst.rstcyc", 1'b1, 3'd0, S_NONE);
        rst = 1'b0;
        check_status("srst.after", 1'b0, 2'd0, 32'd0);
        cyc("srst.fetch", 1'b1, 3'd0, S_FETCH);

`ifdef SEQ_MEM_TIMEOUT_EN
        // watchdog at MEM_TIMEOUT=4: four waits in FETCH trap with cause 3
        do_reset();
        opcode = OP_ADD;
        cyc("wd.w1", 1'b0, 3'd0, S_FWAIT);
        cyc("wd.w2", 1'b0, 3'd0, S_FWAIT);
        cyc("wd.w3", 1'b0, 3'd0, S_FWAIT);
        cyc("wd.w4", 1'b0, 3'd0, S_FWAIT);
        cyc("wd.trap", 1'b0, 3'd5, S_NONE);
        check_status("wd.trap", 1'b1, 2'd3, 32'd0);
        do_reset();
        cyc("wd2.w1", 1'b0, 3'd0, S_FWAIT);
        cyc("wd2.w2", 1'b0, 3'd0, S_FWAIT);
        cyc("wd2.w3", 1'b0, 3'd0, S_FWAIT);
        cyc("wd2.c4", 1'b1, 3'd0, S_FETCH);
        cyc("wd2.dec", 1'b1, 3'd1, S_NONE);
        check_status("wd2.ok", 1'b0, 2'd0, 32'd0);
`else
        // without the watchdog, a long fetch wait never traps
        do_reset();
        opcode = OP_ADD;
        for (int i = 0; i < 6; i++) begin
            cyc($sformatf("nowd.w%0d", i), 1'b0, 3'd0, S_FWAIT);
        end
        cyc("nowd.done", 1'b1, 3'd0, S_FETCH);
        cyc("nowd.dec", 1'b1, 3'd1, S_NONE);
        check_status("nowd.ok", 1'b0, 2'd0, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
